// File: rtl/line_memory.sv
// Line-granular main memory model: one 4-word line per request, returned after a
// fixed latency, with a single request in flight and a shared bidirectional data bus.
module line_memory #(
    parameter int WORD_SIZE = 16,
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   readM,
    input  logic                   writeM,
    input  logic [WORD_SIZE-1:0]   address,
    inout  wire  [4*WORD_SIZE-1:0] data,
    output logic                   input_readyM,
    output logic                   readyM,
    output logic                   doneM,
    output logic [WORD_SIZE-1:0]   written_address,
    output logic [WORD_SIZE-1:0]   read_count,
    output logic [WORD_SIZE-1:0]   write_count
);
    localparam int LINE_W   = 4 * WORD_SIZE;
    localparam int LINES    = MEM_WORDS / 4;
    localparam int IDX_W    = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(LINES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        RESP
    } state_t;

    state_t               state_reg;
    logic                 is_read_reg;
    logic [IDX_W-1:0]     base_reg;
    logic [LINE_W-1:0]    wdata_reg;
    logic [LINE_W-1:0]    rdata_reg;
    logic [CNT_W-1:0]     count_reg;
    logic                 ready_reg;
    logic                 done_reg;
    logic [WORD_SIZE-1:0] written_address_reg;
    logic [WORD_SIZE-1:0] read_count_reg;
    logic [WORD_SIZE-1:0] write_count_reg;

    // Stored as whole lines so a single access moves all four lanes.
    logic [LINE_W-1:0]    line_mem [LINES];

    logic [IDX_W-1:0]     addr_idx;
    logic                 count_zero;
    logic                 mem_we;
    logic                 mem_re;

    // Dropping bits [1:0] and masking to the array depth gives the modulo wrap.
    assign addr_idx   = IDX_W'(address >> 2) & IDX_MASK;
    assign count_zero = (count_reg == '0);
    // Reset gates the commit so a write aborted on its commit edge never lands.
    assign mem_we     = (state_reg == WR_WAIT) && count_zero && !reset_n;
    assign mem_re     = (state_reg == RD_WAIT) && count_zero;

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_reg           <= IDLE;
            is_read_reg         <= 1'b0;
            base_reg            <= '0;
            wdata_reg           <= '0;
            count_reg           <= '0;
            ready_reg           <= 1'b0;
            done_reg            <= 1'b0;
            written_address_reg <= '0;
            read_count_reg      <= '0;
            write_count_reg     <= '0;
        end else begin
            ready_reg <= 1'b0;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (readM || writeM) begin
                        is_read_reg <= readM;
                        base_reg    <= addr_idx;
                        wdata_reg   <= data;
                        count_reg   <= LAT_LOAD;
                        state_reg   <= readM ? RD_WAIT : WR_WAIT;
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (count_zero) begin
                        state_reg <= RESP;
                        ready_reg <= is_read_reg;
                        done_reg  <= !is_read_reg;
                        if (!is_read_reg) begin
                            written_address_reg <= WORD_SIZE'({base_reg, 2'b00});
                        end
                    end else begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    if (is_read_reg) begin
                        read_count_reg <= read_count_reg + 1'b1;
                    end else begin
                        write_count_reg <= write_count_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Array has no reset; contents persist across reset and are preloaded externally.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            line_mem[base_reg] <= wdata_reg;
        end
        if (mem_re) begin
            rdata_reg <= line_mem[base_reg];
        end
    end

    assign input_readyM    = (state_reg == IDLE) && !reset_n;
    assign readyM          = ready_reg;
    assign doneM           = done_reg;
    assign written_address = written_address_reg;
    assign read_count      = read_count_reg;
    assign write_count     = write_count_reg;
    assign data            = ready_reg ? rdata_reg : {LINE_W{1'bz}};

endmodule

// File: tb/tb_line_memory.sv
// Self-checking bench for line_memory: directed scenarios plus random requests,
// compared against a word-array reference model of the memory and its counters.
module tb_line_memory;
    localparam int WS  = 16;
    localparam int MW  = 1024;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          readM;
    logic          writeM;
    logic [WS-1:0] address;
    wire  [63:0]   data;
    logic [63:0]   tb_data;
    logic          tb_drive;
    logic          input_readyM;
    logic          readyM;
    logic          doneM;
    logic [WS-1:0] written_address;
    logic [WS-1:0] read_count;
    logic [WS-1:0] write_count;

    assign data = tb_drive ? tb_data : {64{1'bz}};

    line_memory #(.WORD_SIZE(WS), .MEM_WORDS(MW), .LATENCY(LAT)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .readM(readM),
        .writeM(writeM),
        .address(address),
        .data(data),
        .input_readyM(input_readyM),
        .readyM(readyM),
        .doneM(doneM),
        .written_address(written_address),
        .read_count(read_count),
        .write_count(write_count)
    );

    always #5 clk = ~clk;

    // Reference model: flat word array plus counters.
    logic [15:0] model_mem [MW];
    logic [15:0] model_rc;
    logic [15:0] model_wc;
    logic [15:0] model_wa;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_line(input int base);
        logic [63:0] l;
        for (int i = 0; i < 4; i++) l[16*i +: 16] = model_mem[base + i];
        return l;
    endfunction

    // One full request; hold keeps the request lines asserted through the wait states.
    task automatic do_req(input bit rd, input bit wr, input logic [15:0] addr,
                          input logic [63:0] wd, input bit hold);
        int          base;
        bit          is_rd;
        bit          is_wr;
        bit          resp;
        logic [63:0] exp_line;
        @(negedge clk);
        check("idle_ready", {63'd0, input_readyM}, 64'd1);
        readM    = rd;
        writeM   = wr;
        address  = addr;
        tb_data  = wd;
        tb_drive = wr;
        base     = int'(addr & 16'hFFFC) % MW;
        is_rd    = rd;
        is_wr    = wr && !rd;
        exp_line = model_line(base);
        @(posedge clk);
        #1;
        if (!hold) begin
            readM  = 1'b0;
            writeM = 1'b0;
        end
        tb_drive = hold && wr && !rd;
        for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge clk);
            resp = (c == LAT + 1);
            check("busy_ready", {63'd0, input_readyM}, 64'd0);
            check("readyM", {63'd0, readyM}, {63'd0, resp && is_rd});
            check("doneM", {63'd0, doneM}, {63'd0, resp && is_wr});
            if (resp && is_rd) check("rd_data", data, exp_line);
            if (resp && is_wr) check("wr_addr_resp", {48'd0, written_address}, 64'(base));
            check("rc_hold", {48'd0, read_count}, {48'd0, model_rc});
            check("wc_hold", {48'd0, write_count}, {48'd0, model_wc});
        end
        if (is_wr) begin
            for (int i = 0; i < 4; i++) model_mem[base + i] = wd[16*i +: 16];
            model_wc = model_wc + 1'b1;
            model_wa = 16'(base);
        end else begin
            model_rc = model_rc + 1'b1;
        end
        @(negedge clk);
        readM    = 1'b0;
        writeM   = 1'b0;
        tb_drive = 1'b0;
        check("ready_after", {63'd0, input_readyM}, 64'd1);
        check("no_pulse", {62'd0, readyM, doneM}, 64'd0);
        check("read_count", {48'd0, read_count}, {48'd0, model_rc});
        check("write_count", {48'd0, write_count}, {48'd0, model_wc});
        check("written_addr", {48'd0, written_address}, {48'd0, model_wa});
        $display("txn %0d rd=%0b wr=%0b addr=%h hold=%0b base=%h line=%h rc=%0d wc=%0d",
                 txn, rd, wr, addr, hold, base[15:0], is_rd ? exp_line : wd, model_rc, model_wc);
        txn++;
    endtask

    // Write accepted, then reset asserted after E2 and released after E3.
    task automatic reset_mid_write(input logic [15:0] addr, input logic [63:0] wd);
        @(negedge clk);
        writeM   = 1'b1;
        readM    = 1'b0;
        address  = addr;
        tb_data  = wd;
        tb_drive = 1'b1;
        @(posedge clk);
        #1;
        writeM   = 1'b0;
        tb_drive = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("rst_busy", {63'd0, input_readyM}, 64'd0);
        check("rst_nodone", {63'd0, doneM}, 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_release_ready", {63'd0, input_readyM}, 64'd1);
        model_rc = '0;
        model_wc = '0;
        model_wa = '0;
        for (int c = 0; c < LAT + 2; c++) begin
            @(negedge clk);
            check("rst_quiet", {62'd0, readyM, doneM}, 64'd0);
        end
        check("rst_rc", {48'd0, read_count}, 64'd0);
        check("rst_wc", {48'd0, write_count}, 64'd0);
        check("rst_wa", {48'd0, written_address}, 64'd0);
        $display("txn %0d reset_mid_write addr=%h", txn, addr);
        txn++;
    endtask

    initial begin
        reset_n  = 1'b1;
        readM    = 1'b0;
        writeM   = 1'b0;
        address  = '0;
        tb_data  = '0;
        tb_drive = 1'b0;
        model_rc = '0;
        model_wc = '0;
        model_wa = '0;
        for (int w = 0; w < MW; w++) model_mem[w] = 16'($urandom);
        model_mem[16'h10] = 16'h1111;
        model_mem[16'h11] = 16'h2222;
        model_mem[16'h12] = 16'h3333;
        model_mem[16'h13] = 16'h4444;
        for (int k = 0; k < MW / 4; k++) dut.line_mem[k] = model_line(4 * k);

        repeat (3) begin
            @(negedge clk);
            check("reset_ready", {63'd0, input_readyM}, 64'd0);
            check("reset_pulses", {62'd0, readyM, doneM}, 64'd0);
            check("reset_counts", {read_count, write_count, written_address}, 64'd0);
        end
        reset_n = 1'b0;
        #1;
        check("release_ready", {63'd0, input_readyM}, 64'd1);

        do_req(1'b1, 1'b0, 16'h0012, 64'd0, 1'b0);
        do_req(1'b0, 1'b1, 16'h0020, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
        do_req(1'b1, 1'b0, 16'h0021, 64'd0, 1'b0);
        do_req(1'b1, 1'b1, 16'h0010, {$urandom, $urandom}, 1'b0);
        do_req(1'b1, 1'b0, 16'h0010, 64'd0, 1'b0);
        reset_mid_write(16'h0030, {$urandom, $urandom});
        do_req(1'b1, 1'b0, 16'h0030, 64'd0, 1'b0);
        do_req(1'b1, 1'b0, 16'h0410, 64'd0, 1'b1);
        do_req(1'b0, 1'b1, 16'h0824, {$urandom, $urandom}, 1'b1);
        do_req(1'b1, 1'b0, 16'h0024, 64'd0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            bit          rd;
            bit          wr;
            logic [15:0] a;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) wr = 1'b1;
            // Bias addresses into a small window so reads often hit earlier writes.
            a = (n % 2 == 0) ? 16'($urandom_range(0, 63)) : 16'($urandom);
            do_req(rd, wr, a, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("gap_quiet", {62'd0, readyM, doneM}, 64'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
